// File: rtl/alu_pkg.sv
// Opcode encodings for the execute-stage ALU, shared with the instruction decoder.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational shifter for SLL/SRL/SRA. Left shifts reuse the right-shift path
// by bit-reversing the operand before and after the shift.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   shamt,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] shifted
);

    logic             is_left;
    logic             fill;
    logic [WIDTH-1:0] rev_in;
    logic [WIDTH-1:0] right_out;

    assign is_left = (op == ALU_SLL);
    // Sign fill only applies to SRA; SLL and SRL shift in zeros.
    assign fill    = (op == ALU_SRA) & data[WIDTH-1];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
            assign rev_in[gi]  = is_left ? data[WIDTH-1-gi] : data[gi];
            assign shifted[gi] = is_left ? right_out[WIDTH-1-gi] : right_out[gi];
        end
    endgenerate

    // Extra top bit carries the fill value into the vacated positions.
    assign right_out = WIDTH'($signed({fill, rev_in}) >>> shamt);

endmodule

// File: rtl/alu_unit.sv
// Registered RISC-V execute-stage ALU: one operation per cycle, one cycle latency,
// result and zero flag registered together.
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [3:0]       alu_control,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero_flag
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] result_next;
    logic [WIDTH-1:0] shift_out;
    logic             lt_signed;
    logic             lt_unsigned;

    alu_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .data    (in1),
        .shamt   (in2[SHW-1:0]),
        .op      (alu_control),
        .shifted (shift_out)
    );

    // True comparisons rather than the sign of in1-in2, so overflow cannot flip them.
    assign lt_signed   = $signed(in1) < $signed(in2);
    assign lt_unsigned = in1 < in2;

    always_comb begin
        result_next = '0;
        if (is_shift_op(alu_control)) begin
            result_next = shift_out;
        end else begin
            case (alu_control)
                ALU_AND:  result_next = in1 & in2;
                ALU_OR:   result_next = in1 | in2;
                ALU_ADD:  result_next = in1 + in2;
                ALU_XOR:  result_next = in1 ^ in2;
                ALU_SUB:  result_next = in1 - in2;
                ALU_SLT:  result_next = {{(WIDTH-1){1'b0}}, lt_signed};
                ALU_SLTU: result_next = {{(WIDTH-1){1'b0}}, lt_unsigned};
                default:  result_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result <= '0;
            zero_flag  <= 1'b0;
        end else begin
            alu_result <= result_next;
            zero_flag  <= (result_next == '0);
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Directed table-driven bench for alu_unit, plus hand-written reset and
// between-edge sequences.
module tb_alu_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        zero_flag;

    int checks;
    int errors;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] exp_res;
        logic        exp_zero;
    } vec_t;

    vec_t vecs [0:23];

    alu_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in1         (in1),
        .in2         (in2),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .zero_flag   (zero_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] exp_res, input logic exp_zero);
        checks++;
        if (alu_result !== exp_res || zero_flag !== exp_zero) begin
            errors++;
            $display("FAIL %s: got result=%08h zero=%b, expected result=%08h zero=%b",
                     name, alu_result, zero_flag, exp_res, exp_zero);
        end else begin
            $display("ok   %s: result=%08h zero=%b", name, alu_result, zero_flag);
        end
    endtask

    task automatic set_vec(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input logic [31:0] r);
        vecs[i].a        = a;
        vecs[i].b        = b;
        vecs[i].op       = op;
        vecs[i].exp_res  = r;
        vecs[i].exp_zero = (r == 32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        set_vec( 0, 32'd23, 32'd42, 4'b0000, 32'd2);
        set_vec( 1, 32'd23, 32'd42, 4'b0001, 32'd63);
        set_vec( 2, 32'd23, 32'd42, 4'b0010, 32'd65);
        set_vec( 3, 32'd23, 32'd42, 4'b0100, 32'hFFFF_FFED);
        set_vec( 4, 32'd23, 32'd42, 4'b1000, 32'd1);
        set_vec( 5, 32'd42, 32'd23, 4'b1000, 32'd0);
        set_vec( 6, 32'd42, 32'd23, 4'b0100, 32'd19);
        set_vec( 7, 32'd42, 32'd42, 4'b0100, 32'd0);
        set_vec( 8, 32'h8000_0000, 32'h7FFF_FFFF, 4'b1000, 32'd1);
        set_vec( 9, 32'h8000_0000, 32'h7FFF_FFFF, 4'b1001, 32'd0);
        set_vec(10, 32'h8000_0000, 32'h7FFF_FFFF, 4'b0010, 32'hFFFF_FFFF);
        set_vec(11, 32'h8000_0000, 32'h0000_0024, 4'b0101, 32'h0000_0000);
        set_vec(12, 32'h8000_0000, 32'h0000_0024, 4'b0110, 32'h0800_0000);
        set_vec(13, 32'h8000_0000, 32'h0000_0024, 4'b0111, 32'hF800_0000);
        set_vec(14, 32'd5, 32'd5, 4'b1111, 32'd0);
        set_vec(15, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0011, 32'h0FF0_0FF0);
        set_vec(16, 32'h0000_0001, 32'hFFFF_FFFF, 4'b0101, 32'h8000_0000);
        set_vec(17, 32'h7FFF_FFF0, 32'h0000_0004, 4'b0111, 32'h07FF_FFFF);
        set_vec(18, 32'h1234_5678, 32'h0000_0020, 4'b0110, 32'h1234_5678);
        set_vec(19, 32'd5, 32'hFFFF_FFFF, 4'b1001, 32'd1);
        set_vec(20, 32'hFFFF_FFFF, 32'd1, 4'b1000, 32'd1);
        set_vec(21, 32'd7, 32'd9, 4'b1010, 32'd0);
        set_vec(22, 32'h8765_4321, 32'h0000_0008, 4'b0101, 32'h6543_2100);
        set_vec(23, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0010, 32'h0000_0000);

        // Reset held with random inputs across several edges.
        rst_n       = 1'b0;
        in1         = $urandom;
        in2         = $urandom;
        alu_control = 4'($urandom_range(0, 15));
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", 32'h0, 1'b0);

        @(negedge clk);
        rst_n       = 1'b1;
        in1         = 32'd100;
        in2         = 32'd1;
        alu_control = 4'b0010;
        @(posedge clk);
        #1;
        check("first_after_reset", 32'd101, 1'b0);

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            in1         = vecs[i].a;
            in2         = vecs[i].b;
            alu_control = vecs[i].op;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_op%04b", i, vecs[i].op), vecs[i].exp_res, vecs[i].exp_zero);
        end

        // Input changes between edges must not reach the outputs.
        @(negedge clk);
        in1         = 32'd10;
        in2         = 32'd3;
        alu_control = 4'b0100;
        @(posedge clk);
        #1;
        in1         = 32'd3;
        in2         = 32'd3;
        #2;
        check("between_edge_hold", 32'd7, 1'b0);
        @(posedge clk);
        #1;
        check("next_edge_update", 32'd0, 1'b1);

        // Undefined code leaves zero_flag high, then async reset mid-cycle clears it.
        @(negedge clk);
        in1         = 32'd5;
        in2         = 32'd5;
        alu_control = 4'b1111;
        @(posedge clk);
        #1;
        check("undef_1111", 32'd0, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_zero_flag", 32'd0, 1'b0);

        // Async reset also discards a nonzero in-flight result.
        @(negedge clk);
        rst_n       = 1'b1;
        in1         = 32'hDEAD_0000;
        in2         = 32'h0000_BEEF;
        alu_control = 4'b0001;
        @(posedge clk);
        #1;
        check("resume_or", 32'hDEAD_BEEF, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_result", 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_ignores_clk", 32'h0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("resume_after_reset", 32'hDEAD_BEEF, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_unit.md
# alu_unit

Registered 32-bit integer ALU for the RISC-V execute stage. Each clock it applies the operation selected by `alu_control` to two 32-bit operands and registers the result together with a zero flag. Branch-compare and address arithmetic in the datapath consume `alu_result` and `zero_flag` one cycle after the operands are presented.

## Interface

Clock and reset are fixed: one clock; reset is asynchronous and active-low.

Parameters:
- `WIDTH`, default 32: operand and result width. Only 32 is required; shift amount is `log2(WIDTH)` bits.

Ports:
- `clk`  in  1  system clock, rising-edge active.
- `rst_n`  in  1  asynchronous active-low reset.
- `in1`  in  WIDTH  operand A (rs1).
- `in2`  in  WIDTH  operand B (rs2 or immediate).
- `alu_control`  in  4  operation select.
- `alu_result`  out  WIDTH  registered result.
- `zero_flag`  out  1  registered flag, 1 when the registered result is all zeros.

## Operation

Opcode map for `alu_control`:
- 0000 AND: `in1 & in2`.
- 0001 OR: `in1 | in2`.
- 0010 ADD: `in1 + in2`, modulo 2^32, carry discarded.
- 0011 XOR: `in1 ^ in2`.
- 0100 SUB: `in1 - in2`, modulo 2^32.
- 0101 SLL: `in1 << in2[4:0]`.
- 0110 SRL: `in1 >> in2[4:0]`, zero fill.
- 0111 SRA: `in1 >>> in2[4:0]`, sign fill.
- 1000 SLT: 1 if `$signed(in1) < $signed(in2)`, else 0, zero-extended.
- 1001 SLTU: 1 if `in1 < in2` unsigned, else 0.
- All other codes (1010–1111): result 0, so `zero_flag` becomes 1.

Rules:
- Shifts use only `in2[4:0]`; `in2[31:5]` is ignored.
- SLT and SLTU use a true comparison, not the sign of the subtraction, so they stay correct on overflow. Example: 0x80000000 < 0x7FFFFFFF signed gives 1.
- `zero_flag` is `(next_result == 0)`, computed from the same combinational value that is registered into `alu_result`.

## Timing

- Latency is exactly 1 cycle. Operands and `alu_control` sampled at rising edge N appear on the outputs after edge N.
- Throughput is one operation per cycle, with no stall and no handshake. The outputs update every cycle.
- While `rst_n` = 0: `alu_result` = 0 and `zero_flag` = 0, asynchronously and regardless of `clk`.
- Operation resumes at the first rising edge after `rst_n` deasserts.
- If reset is asserted mid-stream, the in-flight result is discarded.
- Input changes between clock edges have no effect on the outputs.

## Structure

- Package `alu_pkg` holds the 4-bit opcode localparams (`ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_XOR`, `ALU_SUB`, `ALU_SLL`, `ALU_SRL`, `ALU_SRA`, `ALU_SLT`, `ALU_SLTU`). The decoder shares this package.
- One sub-module, `alu_shifter`, is combinational and handles SLL, SRL and SRA. The rest is a combinational case statement followed by the output register.

## Test plan

- Reset: hold `rst_n` = 0 with random inputs → `alu_result` = 0 and `zero_flag` = 0. After release, the first edge gives a valid result.
- in1 = 23, in2 = 42, codes 0000 / 0001 / 0010 / 0100 / 1000 on successive cycles → results 2, 63, 65, 0xFFFFFFED, 1, each one cycle later. `zero_flag` = 0 for all.
- in1 = 42, in2 = 23: SLT → 0 with `zero_flag` = 1; SUB → 19. Then in1 = in2 = 42, SUB → 0 with `zero_flag` = 1.
- Overflow compare: in1 = 0x80000000, in2 = 0x7FFFFFFF. SLT → 1, SLTU → 0, ADD → 0xFFFFFFFF.
- Shifts with in1 = 0x80000000, in2 = 0x00000024 (shift amount 4): SLL → 0, SRL → 0x08000000, SRA → 0xF8000000.
- Undefined code 1111 with in1 = in2 = 5 → result 0, `zero_flag` = 1. Then assert `rst_n` low between edges → outputs clear immediately.
